chunked_serial_adder: RTL
=========================

// Module: chunked_serial_adder
// PURPOSE
//  Multi-cycle, parametrised successor to the single-bit full adder.
//  Adds two WIDTH-bit operands CHUNK bits per clock using an internal CHUNK-bit ripple chain of full adders.
//  A registered carry passes between chunks. A start/busy/done handshake frames each operation.
//  Intended as the area-lean adder for the ALU datapath where a full-width ripple chain misses timing.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK    8  bits added per cycle (1..WIDTH); NCHUNK = WIDTH/CHUNK derived localparam
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  in1    in   WIDTH  operand A, captured on accepted start
//  in2    in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in, captured on accepted start
//  sub    in   1      subtract select (present only with CHUNK_ADDER_SUB_EN)
//  busy   out  1      operation in progress
//  done   out  1      one-cycle pulse: out/cout/ovf valid
//  out    out  WIDTH  sum, held until the next done
//  cout   out  1      carry out of bit WIDTH-1
//  ovf    out  1      signed overflow = carry into MSB XOR cout
// BEHAVIOUR
//  Reset (async, any time, including mid-operation):
//   - state=IDLE; busy=0, done=0, out=0, cout=0, ovf=0
//   - chunk index=0; captured operands discarded
//  FSM states: IDLE, RUN.
//   IDLE: start=1 at edge k captures in1/in2/cin, sets idx=0, busy=1 -> RUN. done forced 0 at this edge.
//   RUN, each edge:
//    - chunk idx = bits [idx*CHUNK +: CHUNK] of A+B+carry written to result register
//    - carry register <- chunk carry-out; idx++
//    - on last chunk (idx=NCHUNK-1): out/cout/ovf update, done=1, busy=0 -> IDLE
//  Latency: start at edge k -> done high after edge k+NCHUNK (one cycle). CHUNK=WIDTH gives latency 1.
//  Throughput: start may be asserted during the done cycle (busy=0) -> back-to-back ops, one per NCHUNK+1 cycles.
//  start while busy=1 is ignored; no queueing. Operand inputs are don't-care except at the accepting edge.
//  out holds the previous result while busy; updates atomically at done (partial chunks internal only).
//  Arithmetic: unsigned modulo 2^WIDTH; cout = bit WIDTH of full sum. ovf per two's-complement rule.
//  done is high for exactly one cycle per accepted start; never asserted without a prior accepted start.
// CONFIGURATION
//  CHUNK_ADDER_SUB_EN defined:
//   - port sub exists, captured with operands
//   - sub=1 computes in1 + ~in2 + 1 (cin ignored); cout=1 means no borrow; ovf = signed subtract overflow
//  Not defined: port sub absent; add only, cin used as given.
// TESTING (WIDTH=32, CHUNK=8 unless stated)
//  1. start; in1=FFFFFFFF, in2=00000001, cin=0
//     -> done 4 cycles after start; out=00000000, cout=1, ovf=0; busy high exactly 4 cycles
//  2. in1=7FFFFFFF, in2=00000001, cin=0
//     -> out=80000000, cout=0, ovf=1
//  3. start held high during busy, operands changed mid-op
//     -> single done, result from first-captured operands only
//  4. rst pulsed 2 cycles after start
//     -> busy/done/out/cout/ovf=0 immediately; no done afterwards until a new start
//  5. start in done cycle with in1=1, in2=2, cin=1
//     -> second done 4 cycles later, out=00000004
//  6. CHUNK=32: 12345678 + 11111111 -> done 1 cycle later, out=23456789.
//     With CHUNK_ADDER_SUB_EN: sub=1, 5-7 -> out=FFFFFFFE, cout=0

Source files
------------

// File: rtl/chunked_serial_adder_if.sv
// Handshake and operand bus for chunked_serial_adder.
// The optional subtract-select line exists only when CHUNK_ADDER_SUB_EN is defined.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
`ifdef CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  // Requester side: drives the operation request, observes status and result.
  modport master (
`ifdef CHUNK_ADDER_SUB_EN
    output sub,
`endif
    output start, in1, in2, cin,
    input  busy, done, out, cout, ovf
  );

  // Adder side: accepts the request, returns status and result.
  modport slave (
`ifdef CHUNK_ADDER_SUB_EN
    input  sub,
`endif
    input  start, in1, in2, cin,
    output busy, done, out, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: adds two WIDTH-bit operands CHUNK bits per clock through
// a CHUNK-bit ripple chain, passing a registered carry between chunks.
// start is accepted only while idle; done pulses for one cycle when out/cout/ovf
// update. out holds the previous result until the whole sum is ready.
// Optional feature macro: CHUNK_ADDER_SUB_EN (adds the sub port; sub=1 computes
// in1 + ~in2 + 1 and ignores cin). WIDTH must be a multiple of CHUNK.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  chunked_serial_adder_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               carry_reg;
  logic               cout_reg;
  logic               ovf_reg;
  logic               done_reg;

  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   b_next;
  logic [WIDTH-1:0]   acc_next;
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   sum_chunk;
  logic [CHUNK:0]     c;
  logic               accept;
  logic               last;
  logic               finish;
  logic               sub_sel;

`ifdef CHUNK_ADDER_SUB_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Operands are consumed from the bottom: the low chunk is always the one in flight.
  assign a_chunk = a_reg[CHUNK-1:0];
  assign b_chunk = b_reg[CHUNK-1:0];
  assign last    = (idx_reg == IDX_W'(NCHUNK - 1));
  assign finish  = (state_reg == RUN) && last;

  // Ripple chain of full adders across one chunk, seeded by the registered carry.
  assign c[0] = carry_reg;
  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign sum_chunk[gi] = a_chunk[gi] ^ b_chunk[gi] ^ c[gi];
      assign c[gi+1]       = (a_chunk[gi] & b_chunk[gi]) | (c[gi] & (a_chunk[gi] ^ b_chunk[gi]));
    end

    // Shift operands down by one chunk and shift each chunk sum in at the top, so
    // after NCHUNK steps chunk 0 of the result sits at bit 0.
    if (NCHUNK > 1) begin : g_shift
      assign a_next   = {{CHUNK{1'b0}}, a_reg[WIDTH-1:CHUNK]};
      assign b_next   = {{CHUNK{1'b0}}, b_reg[WIDTH-1:CHUNK]};
      assign acc_next = {sum_chunk, acc_reg[WIDTH-1:CHUNK]};
    end else begin : g_single
      assign a_next   = '0;
      assign b_next   = '0;
      assign acc_next = sum_chunk;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: accept a request only when idle, leave RUN after the last chunk.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, add one chunk per RUN cycle, publish at finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      out_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= finish;
      if (accept) begin
        idx_reg   <= '0;
        a_reg     <= bus.in1;
        // Subtraction is addition of the inverted operand with a forced carry-in.
        b_reg     <= bus.in2 ^ {WIDTH{sub_sel}};
        carry_reg <= sub_sel | bus.cin;
        acc_reg   <= '0;
      end else if (state_reg == RUN) begin
        idx_reg   <= finish ? '0 : idx_reg + IDX_W'(1);
        a_reg     <= a_next;
        b_reg     <= b_next;
        carry_reg <= c[CHUNK];
        acc_reg   <= acc_next;
        if (finish) begin
          out_reg  <= acc_next;
          cout_reg <= c[CHUNK];
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_reg  <= c[CHUNK] ^ c[CHUNK-1];
        end
      end
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = done_reg;
  assign bus.out  = out_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;

endmodule
